// File: rtl/mem_stage_rr_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : mem_stage_rr_if                                                   |
// | Brief    : EXE->MEM->WB handshake, data-SRAM response and forwarding bundle |
// | Revision : 1.0                                                               |
// +-----------------------------------------------------------------------------+
interface mem_stage_rr_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    localparam int c_EXE_W = 3*XLEN + REG_AW + 7;
    localparam int c_WB_W  = 3*XLEN + REG_AW + 1;
    localparam int c_WR_W  = XLEN + REG_AW + 2;

    logic               EXE_to_MEM_valid;
    logic               MEM_allow_in;
    logic [c_EXE_W-1:0] EXE_to_MEM_bus;
    logic               MEM_to_WB_valid;
    logic               WB_allow_in;
    logic [c_WB_W-1:0]  MEM_to_WB_bus;
    logic               MEM_flush;
    logic               data_sram_data_ok;
    logic [XLEN-1:0]    data_sram_rdata;
    logic [c_WR_W-1:0]  MEM_wr_bus;

    modport slave (
        input  EXE_to_MEM_valid, EXE_to_MEM_bus, WB_allow_in, MEM_flush,
        input  data_sram_data_ok, data_sram_rdata,
        output MEM_allow_in, MEM_to_WB_valid, MEM_to_WB_bus, MEM_wr_bus
    );

    modport master (
        output EXE_to_MEM_valid, EXE_to_MEM_bus, WB_allow_in, MEM_flush,
        output data_sram_data_ok, data_sram_rdata,
        input  MEM_allow_in, MEM_to_WB_valid, MEM_to_WB_bus, MEM_wr_bus
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_rr.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : mem_stage_rr                                                      |
// | Brief    : MEM pipeline stage for a request/response data SRAM; optional    |
// |            byte/half load extraction enabled by `define MEM_LD_EXT_EN       |
// | Revision : 1.0                                                               |
// +-----------------------------------------------------------------------------+
module mem_stage_rr #(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int MAX_OUTST = 2
) (
    input  wire logic      clk,
    input  wire logic      resetn,
    mem_stage_rr_if.slave  io_bus
);
    localparam int c_EXE_W    = 3*XLEN + REG_AW + 7;
    localparam int c_CNT_W    = $clog2(MAX_OUTST + 1);
    localparam int c_SUM_W    = c_CNT_W + 2;
    localparam int c_PC_LSB   = XLEN;
    localparam int c_DEST_LSB = 2*XLEN;
    localparam int c_WE_BIT   = 2*XLEN + REG_AW;
    localparam int c_LDT_LSB  = c_WE_BIT + 1;
    localparam int c_MREQ_BIT = c_LDT_LSB + 3;
    localparam int c_RFM_BIT  = c_MREQ_BIT + 1;
    localparam int c_ALU_LSB  = c_RFM_BIT + 1;

    logic               r_valid;
    logic [c_EXE_W-1:0] r_bus;
    logic               r_resp_got;
    logic [XLEN-1:0]    r_resp_buf;
    logic [c_CNT_W-1:0] r_discard_cnt;

    logic [XLEN-1:0]    w_inst;
    logic [XLEN-1:0]    w_pc;
    logic [REG_AW-1:0]  w_dest;
    logic               w_gr_we;
    logic               w_mem_req;
    logic               w_res_from_mem;
    logic [XLEN-1:0]    w_alu_result;
    logic               w_exe_mem_req;

    logic               w_discarding;
    logic               w_own_ok;
    logic               w_drop_ok;
    logic               w_ready_go;
    logic               w_to_wb_valid;
    logic               w_allow_in;
    logic               w_handoff;
    logic               w_load;
    logic               w_ld_pending;
    logic [XLEN-1:0]    w_mem_data;
    logic [XLEN-1:0]    w_ld_val;
    logic [XLEN-1:0]    w_final;
    logic               w_inc_mem;
    logic               w_inc_exe;
    logic [c_SUM_W-1:0] w_cnt_sum;
    logic               w_unused;

    assign w_inst         = r_bus[c_PC_LSB-1:0];
    assign w_pc           = r_bus[c_PC_LSB +: XLEN];
    assign w_dest         = r_bus[c_DEST_LSB +: REG_AW];
    assign w_gr_we        = r_bus[c_WE_BIT];
    assign w_mem_req      = r_bus[c_MREQ_BIT];
    assign w_res_from_mem = r_bus[c_RFM_BIT];
    assign w_alu_result   = r_bus[c_ALU_LSB +: XLEN];
    assign w_exe_mem_req  = io_bus.EXE_to_MEM_bus[c_MREQ_BIT];

    // Pulses arriving while discard_cnt is non-zero belong to cancelled requests.
    always_comb begin
        w_discarding  = (r_discard_cnt != '0);
        w_own_ok      = io_bus.data_sram_data_ok & ~w_discarding & r_valid & w_mem_req & ~r_resp_got;
        w_drop_ok     = io_bus.data_sram_data_ok & w_discarding;
        w_ready_go    = ~w_mem_req | r_resp_got | w_own_ok;
        w_to_wb_valid = r_valid & w_ready_go & ~io_bus.MEM_flush;
        w_allow_in    = ~r_valid | (w_ready_go & io_bus.WB_allow_in);
        w_handoff     = w_to_wb_valid & io_bus.WB_allow_in;
        w_load        = io_bus.EXE_to_MEM_valid & w_allow_in & ~io_bus.MEM_flush;
        w_ld_pending  = r_valid & w_res_from_mem & ~w_ready_go;
        w_mem_data    = r_resp_got ? r_resp_buf : io_bus.data_sram_rdata;
    end

`ifdef MEM_LD_EXT_EN
    logic [2:0]  w_ld_type;
    logic [1:0]  w_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_ld_type = r_bus[c_LDT_LSB +: 3];
    assign w_off     = w_alu_result[1:0];

    always_comb begin
        w_byte = w_mem_data[{w_off, 3'b000} +: 8];
        w_half = w_mem_data[{w_off[1], 4'b0000} +: 16];
        case (w_ld_type)
            3'b001:  w_ld_val = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b010:  w_ld_val = {{(XLEN-8){1'b0}}, w_byte};
            3'b011:  w_ld_val = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_ld_val = {{(XLEN-16){1'b0}}, w_half};
            default: w_ld_val = w_mem_data;
        endcase
    end

    assign w_unused = ^{r_bus[c_EXE_W-1], w_cnt_sum[c_SUM_W-1:c_CNT_W]};
`else
    assign w_ld_val = w_mem_data;
    assign w_unused = ^{r_bus[c_EXE_W-1], r_bus[c_LDT_LSB +: 3], w_cnt_sum[c_SUM_W-1:c_CNT_W]};
`endif

    assign w_final = w_res_from_mem ? w_ld_val : w_alu_result;

    // A pulse consumed this cycle by the flushed entry is not owed any more.
    always_comb begin
        w_inc_mem = io_bus.MEM_flush & r_valid & w_mem_req & ~r_resp_got & ~w_own_ok;
        w_inc_exe = io_bus.MEM_flush & io_bus.EXE_to_MEM_valid & w_exe_mem_req;
        w_cnt_sum = c_SUM_W'(r_discard_cnt) + c_SUM_W'(w_inc_mem)
                  + c_SUM_W'(w_inc_exe) - c_SUM_W'(w_drop_ok);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid       <= 1'b0;
            r_resp_got    <= 1'b0;
            r_discard_cnt <= '0;
        end else begin
            if (io_bus.MEM_flush) begin
                r_valid <= 1'b0;
            end else if (w_allow_in) begin
                r_valid <= io_bus.EXE_to_MEM_valid;
            end

            if (io_bus.MEM_flush | w_load | w_handoff) begin
                r_resp_got <= 1'b0;
            end else if (w_own_ok) begin
                r_resp_got <= 1'b1;
            end

            r_discard_cnt <= w_cnt_sum[c_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_bus <= io_bus.EXE_to_MEM_bus;
        end
        if (w_own_ok & ~w_handoff) begin
            r_resp_buf <= io_bus.data_sram_rdata;
        end
    end

    a_discard_bound : assert property (@(posedge clk) disable iff (!resetn)
        w_cnt_sum <= c_SUM_W'(MAX_OUTST));

    assign io_bus.MEM_allow_in    = w_allow_in;
    assign io_bus.MEM_to_WB_valid = w_to_wb_valid;
    assign io_bus.MEM_to_WB_bus   = {w_final, w_gr_we, w_dest, w_pc, w_inst};
    assign io_bus.MEM_wr_bus      = {w_gr_we & r_valid, w_ld_pending, w_dest, w_final};

endmodule
`default_nettype wire
